// File: rtl/fpnew_pkg.sv
// ---------------------------------------------------------------------------
// fpnew_pkg (slice)
//
// Shared constants and helper functions for the sdotp request arbiter and
// its requester-ID FIFO.
//   SDOTP_ARB_MAX_REQ    : upper bound on the number of requester ports
//   sdotp_arb_id_width() : bits needed to hold a requester index (min 1)
//   sdotp_arb_ptr_width(): bits needed for a FIFO pointer (min 1)
// ---------------------------------------------------------------------------
package fpnew_pkg;

    localparam int SDOTP_ARB_MAX_REQ = 16;

    // A single requester still needs one bit so the ID never collapses to zero width.
    function automatic int sdotp_arb_id_width(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

    function automatic int sdotp_arb_ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fpnew_sdotp_arb_idfifo.sv
// ---------------------------------------------------------------------------
// fpnew_sdotp_arb_idfifo
//
// In-order FIFO holding the requester ID of every operation in flight in the
// shared sdotp unit. Pointers wrap modulo Depth, so Depth need not be a power
// of two. A simultaneous push and pop leaves the count unchanged, even when
// the FIFO is full. Flush empties the FIFO on the next edge and overrides
// any push or pop in the same cycle.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   flush_i          drop every stored ID
//   push_i, data_i   write an ID
//   pop_i, data_o    consume the head ID (data_o is the head entry)
//   full_o, empty_o  occupancy flags
//   count_o          number of stored IDs
// ---------------------------------------------------------------------------
module fpnew_sdotp_arb_idfifo
    import fpnew_pkg::*;
#(
    parameter int Depth = 4,
    parameter int Width = 2,
    localparam int PtrW = sdotp_arb_ptr_width(Depth),
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpnew_sdotp_arbiter.sv
// ---------------------------------------------------------------------------
// fpnew_sdotp_arbiter
//
// Shares one sdotp unit between NumReq requesters. At most one operation is
// issued per cycle. The issuing requester ID is recorded in an in-order FIFO,
// and each returning result is steered back to that requester. Grant and
// response paths are purely combinational.
//
// Build option: FPNEW_SDOTP_ARB_PRIO_EN selects fixed priority, where the
// lowest index wins and no round-robin pointer exists. It is undefined by
// default, which gives round-robin arbitration.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   flush_i                          drop all in-flight operations
//   req_valid_i/req_ready_o/req_data_i  per-requester issue handshake
//   unit_valid_o/unit_ready_i/unit_data_o/unit_flush_o  shared unit input
//   unit_out_valid_i/unit_out_ready_o/unit_result_i     shared unit output
//   rsp_valid_o/rsp_ready_i/rsp_data_o  per-requester response handshake
//   busy_o                           operations in flight
//   err_o                            sticky: result arrived with no ID pending
// ---------------------------------------------------------------------------
module fpnew_sdotp_arbiter
    import fpnew_pkg::*;
#(
    parameter int NumReq      = 4,
    parameter int ReqWidth    = 256,
    parameter int RspWidth    = 134,
    parameter int MaxInflight = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0][ReqWidth-1:0]  req_data_i,
    output logic                             unit_valid_o,
    input  logic                             unit_ready_i,
    output logic [ReqWidth-1:0]              unit_data_o,
    output logic                             unit_flush_o,
    input  logic                             unit_out_valid_i,
    output logic                             unit_out_ready_o,
    input  logic [RspWidth-1:0]              unit_result_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    input  logic [NumReq-1:0]                rsp_ready_i,
    output logic [RspWidth-1:0]              rsp_data_o,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int IdW  = sdotp_arb_id_width(NumReq);
    localparam int CntW = $clog2(MaxInflight + 1);

    logic [IdW-1:0]  gnt;
    logic            any_valid;
    logic            can_issue;
    logic            issue;
    logic            pop;
    logic            orphan;
    logic [IdW-1:0]  head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            err_q, err_d;

    assign any_valid = |req_valid_i;

`ifdef FPNEW_SDOTP_ARB_PRIO_EN
    // Scan from the top down so the lowest valid index is the last write.
    always_comb begin
        gnt = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid_i[i]) gnt = IdW'(i);
        end
    end
`else
    logic [IdW-1:0] rr_q, rr_d;
    logic           found;

    // Walk the requesters starting at the pointer; the first valid one wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req_valid_i[(int'(rr_q) + i) % NumReq]) begin
                gnt   = IdW'((int'(rr_q) + i) % NumReq);
                found = 1'b1;
            end
        end
    end

    // The pointer only moves past a requester once its operation is accepted.
    always_comb begin
        rr_d = rr_q;
        if (issue) rr_d = IdW'((int'(gnt) + 1) % NumReq);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_q <= '0;
        else       rr_q <= rr_d;
    end
`endif

    // Issue side: the flush cycle never pushes, and a full ID FIFO blocks issue.
    always_comb begin
        can_issue    = ~fifo_full & ~flush_i;
        unit_valid_o = can_issue & any_valid;
        unit_data_o  = any_valid ? req_data_i[gnt] : '0;
        req_ready_o  = '0;
        if (any_valid) req_ready_o[gnt] = can_issue & unit_ready_i;
        issue        = unit_valid_o & unit_ready_i;
    end

    // Response side: a result with no pending ID is drained and flagged, never delivered.
    always_comb begin
        rsp_valid_o = '0;
        if (!fifo_empty) rsp_valid_o[head] = unit_out_valid_i;
        unit_out_ready_o = fifo_empty ? unit_out_valid_i : rsp_ready_i[head];
        pop    = unit_out_valid_i & unit_out_ready_o & ~fifo_empty;
        orphan = unit_out_valid_i & fifo_empty;
        err_d  = err_q | orphan;
    end

    assign rsp_data_o   = unit_result_i;
    assign unit_flush_o = flush_i;
    assign busy_o       = (fifo_count != '0);
    assign err_o        = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    fpnew_sdotp_arb_idfifo #(
        .Depth (MaxInflight),
        .Width (IdW)
    ) i_idfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (issue),
        .data_i  (gnt),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
